// File: rtl/park_pkg.sv
// Shared types and helpers for the car-park ticketing and fee unit.
package park_pkg;

  localparam int FEE_W  = 4;
  localparam int TIME_W = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ALLOC   = 3'd1,
    S_LOOKUP  = 3'd2,
    S_QUOTE   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  // Ceiling log2, never below 1, so that single-entry configurations keep a real index bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/park_timebase.sv
// Free-running seconds timebase: a clk prescaler feeding a 32-bit seconds counter.
module park_timebase import park_pkg::*; #(
  parameter int CLK_PER_SEC = 1000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [TIME_W-1:0] now_sec
);

  localparam int             PW   = clog2_min1(CLK_PER_SEC);
  localparam logic [PW-1:0]  LAST = PW'(CLK_PER_SEC - 1);

  logic [PW-1:0] presc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      now_sec <= '0;
    end else if (presc == LAST) begin
      presc   <= '0;
      now_sec <= now_sec + TIME_W'(1);
    end else begin
      presc   <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/park_billing.sv
// Car-park ticket allocation, elapsed-time fee quoting and payment release.
// Optional grace period (free short stays) is enabled by defining PARK_GRACE_EN.
module park_billing import park_pkg::*; #(
  parameter  int PMAX         = 5,
  parameter  int CLK_PER_SEC  = 1000,
  parameter  int SEC_PER_HOUR = 3600,
  parameter  int FEE_MAX      = 5,
  parameter  int GRACE_SEC    = 600,
  localparam int ID_W         = clog2_min1(PMAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              entry_req,
  output logic              entry_ack,
  output logic [ID_W-1:0]   ticket_id,
  output logic              entry_full,
  output logic [ID_W:0]     free_slots,
  input  logic              exit_req,
  input  logic [ID_W-1:0]   exit_ticket,
  output logic              fee_valid,
  output logic [FEE_W-1:0]  fee,
  input  logic              pay,
  output logic              paid,
  output logic              exit_err,
  output logic [TIME_W-1:0] now_sec
);

`ifdef PARK_GRACE_EN
  localparam bit GRACE_ON = 1'b1;
`else
  localparam bit GRACE_ON = 1'b0;
`endif
  localparam logic [TIME_W-1:0] GRACE_T = TIME_W'(GRACE_SEC);

  state_t            state, state_n;
  logic [PMAX-1:0]   valid;
  logic [TIME_W-1:0] ts [PMAX];
  logic [TIME_W-1:0] elapsed_q;
  logic [ID_W-1:0]   rel_id;

  logic [ID_W-1:0]   alloc_id;
  logic [ID_W:0]     used;
  logic              sel_valid;
  logic [TIME_W-1:0] sel_ts;
  logic [TIME_W-1:0] look_elapsed;
  logic              grace_hit;
  logic [FEE_W-1:0]  fee_calc;

  park_timebase #(.CLK_PER_SEC(CLK_PER_SEC)) u_timebase (
    .clk     (clk),
    .rst     (rst),
    .now_sec (now_sec)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    alloc_id = '0;
    for (int i = PMAX - 1; i >= 0; i--) begin
      if (!valid[i]) alloc_id = ID_W'(i);
    end
  end

  always_comb begin
    used = '0;
    for (int i = 0; i < PMAX; i++) begin
      used = used + (ID_W+1)'(valid[i]);
    end
  end

  // Tickets at or beyond PMAX never match a slot, so they read back as unallocated.
  always_comb begin
    sel_valid = 1'b0;
    sel_ts    = '0;
    for (int i = 0; i < PMAX; i++) begin
      if (exit_ticket == ID_W'(i)) begin
        sel_valid = valid[i];
        sel_ts    = ts[i];
      end
    end
  end

  assign look_elapsed = now_sec - sel_ts;
  assign grace_hit    = GRACE_ON && (look_elapsed < GRACE_T);

  // Fee is one plus the number of whole-hour thresholds passed, capped by FEE_MAX.
  always_comb begin
    fee_calc = FEE_W'(1);
    for (int k = 1; k < FEE_MAX; k++) begin
      if (elapsed_q >= TIME_W'(k * SEC_PER_HOUR)) fee_calc = fee_calc + FEE_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (entry_req && !entry_full)  state_n = S_ALLOC;
        else if (exit_req && !exit_err) state_n = S_LOOKUP;
      end
      S_ALLOC:   state_n = S_IDLE;
      S_LOOKUP: begin
        if (!sel_valid)     state_n = S_IDLE;
        else if (grace_hit) state_n = S_RELEASE;
        else                state_n = S_QUOTE;
      end
      S_QUOTE:   if (pay) state_n = S_RELEASE;
      S_RELEASE: state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // exit_err is still high on the first IDLE cycle back, while the requester drops its
  // request; masking exit_req there stops the same bad ticket being rejected twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      valid     <= '0;
      exit_err  <= 1'b0;
      elapsed_q <= '0;
      rel_id    <= '0;
    end else begin
      state    <= state_n;
      exit_err <= (state == S_LOOKUP) && !sel_valid;
      if (state == S_ALLOC)   valid[alloc_id] <= 1'b1;
      if (state == S_RELEASE) valid[rel_id]   <= 1'b0;
      if (state == S_LOOKUP) begin
        elapsed_q <= look_elapsed;
        rel_id    <= exit_ticket;
      end
    end
  end

  // NOTE: timestamps are not reset; a slot's timestamp is only read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (state == S_ALLOC) ts[alloc_id] <= now_sec;
  end

  assign free_slots = (ID_W+1)'(PMAX) - used;
  assign entry_full = (free_slots == '0);
  assign entry_ack  = (state == S_ALLOC);
  assign ticket_id  = (state == S_ALLOC) ? alloc_id : '0;
  assign fee_valid  = (state == S_QUOTE);
  assign fee        = (state == S_QUOTE) ? fee_calc : '0;
  assign paid       = (state == S_RELEASE);

endmodule

// File: tb/tb_park_billing.sv
// Directed self-checking bench for park_billing (1 s per clk, 10 s billing hour, 3 slots).
module tb_park_billing;
  import park_pkg::*;

  localparam int PMAX = 3;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              entry_req = 1'b0;
  logic              entry_ack;
  logic [ID_W-1:0]   ticket_id;
  logic              entry_full;
  logic [ID_W:0]     free_slots;
  logic              exit_req = 1'b0;
  logic [ID_W-1:0]   exit_ticket = '0;
  logic              fee_valid;
  logic [FEE_W-1:0]  fee;
  logic              pay = 1'b0;
  logic              paid;
  logic              exit_err;
  logic [TIME_W-1:0] now_sec;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int alloc_cyc [PMAX];

  park_billing #(
    .PMAX(PMAX), .CLK_PER_SEC(1), .SEC_PER_HOUR(10), .FEE_MAX(5), .GRACE_SEC(5)
  ) dut (
    .clk(clk), .rst(rst),
    .entry_req(entry_req), .entry_ack(entry_ack), .ticket_id(ticket_id),
    .entry_full(entry_full), .free_slots(free_slots),
    .exit_req(exit_req), .exit_ticket(exit_ticket),
    .fee_valid(fee_valid), .fee(fee), .pay(pay), .paid(paid),
    .exit_err(exit_err), .now_sec(now_sec)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Reference fee: one per started 10 s hour, capped at 5.
  function automatic int fee_model(input int e);
    int f;
    f = e / 10 + 1;
    return (f > 5) ? 5 : f;
  endfunction

  task automatic do_entry(input int exp_id, input int exp_free);
    entry_req = 1'b1;
    @(negedge clk);
    check("entry_ack", 32'(entry_ack), 1);
    check("ticket_id", 32'(ticket_id), exp_id);
    alloc_cyc[exp_id] = cyc;
    entry_req = 1'b0;
    @(negedge clk);
    check("entry_ack_pulse", 32'(entry_ack), 0);
    check("free_after_entry", 32'(free_slots), exp_free);
  endtask

  task automatic exit_pay(input int tk, input int exp_fee, input int exp_free);
    exit_req = 1'b1;
    exit_ticket = ID_W'(tk);
    @(negedge clk);
    check("lookup_no_fee", 32'(fee_valid), 0);
    @(negedge clk);
    check("fee_valid", 32'(fee_valid), 1);
    check("fee", 32'(fee), exp_fee);
    exit_req = 1'b0;
    @(negedge clk);
    check("fee_hold", 32'(fee_valid), 1);
    pay = 1'b1;
    @(negedge clk);
    check("paid", 32'(paid), 1);
    pay = 1'b0;
    @(negedge clk);
    check("paid_pulse", 32'(paid), 0);
    check("free_after_pay", 32'(free_slots), exp_free);
  endtask

  task automatic exit_bad(input int tk, input int exp_free);
    exit_req = 1'b1;
    exit_ticket = ID_W'(tk);
    @(negedge clk);
    check("err_not_early", 32'(exit_err), 0);
    @(negedge clk);
    check("exit_err", 32'(exit_err), 1);
    check("err_no_fee", 32'(fee_valid), 0);
    exit_req = 1'b0;
    @(negedge clk);
    check("exit_err_pulse", 32'(exit_err), 0);
    check("err_free_same", 32'(free_slots), exp_free);
  endtask

  task automatic timed_fee(input int e, input int exp_fee);
    do_entry(0, 0);
    repeat (e - 2) @(negedge clk);
    exit_pay(0, exp_fee, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_free", 32'(free_slots), 3);
    check("rst_full", 32'(entry_full), 0);
    check("rst_ack", 32'(entry_ack), 0);
    check("rst_id", 32'(ticket_id), 0);
    check("rst_fee_valid", 32'(fee_valid), 0);
    check("rst_fee", 32'(fee), 0);
    check("rst_paid", 32'(paid), 0);
    check("rst_err", 32'(exit_err), 0);
    check("rst_now", now_sec, 0);
    rst = 1'b0;
    @(negedge clk);

    do_entry(0, 2);
    do_entry(1, 1);
    do_entry(2, 0);
    check("full", 32'(entry_full), 1);
    entry_req = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("full_no_ack", 32'(entry_ack), 0);
    end
    entry_req = 1'b0;
    @(negedge clk);

    exit_bad(3, 0);

    exit_pay(1, fee_model(cyc + 1 - alloc_cyc[1]), 1);
    do_entry(1, 0);

    exit_pay(0, fee_model(cyc + 1 - alloc_cyc[0]), 1);
    exit_bad(0, 1);

    timed_fee(9, 1);
    timed_fee(10, 2);
    timed_fee(39, 4);
    timed_fee(40, 5);
    timed_fee(100, 5);

    // Entry and exit together: entry wins, exit follows once entry_req drops.
    entry_req = 1'b1;
    exit_req = 1'b1;
    exit_ticket = ID_W'(2);
    @(negedge clk);
    check("sim_entry_ack", 32'(entry_ack), 1);
    check("sim_ticket", 32'(ticket_id), 0);
    check("sim_no_fee", 32'(fee_valid), 0);
    entry_req = 1'b0;
    @(negedge clk);
    check("sim_idle_no_fee", 32'(fee_valid), 0);
    @(negedge clk);
    check("sim_lookup_no_fee", 32'(fee_valid), 0);
    @(negedge clk);
    check("sim_fee_valid", 32'(fee_valid), 1);
    check("sim_fee", 32'(fee), fee_model(cyc - 1 - alloc_cyc[2]));
    exit_req = 1'b0;

    rst = 1'b1;
    @(negedge clk);
    check("midrst_fee_valid", 32'(fee_valid), 0);
    check("midrst_free", 32'(free_slots), 3);
    check("midrst_full", 32'(entry_full), 0);
    check("midrst_now", now_sec, 0);
    rst = 1'b0;
    @(negedge clk);
    do_entry(0, 2);

`ifdef PARK_GRACE_EN
    @(negedge clk);
    exit_req = 1'b1;
    exit_ticket = ID_W'(0);
    @(negedge clk);
    check("grace_lookup_paid", 32'(paid), 0);
    @(negedge clk);
    check("grace_paid", 32'(paid), 1);
    check("grace_no_quote", 32'(fee_valid), 0);
    check("grace_fee", 32'(fee), 0);
    exit_req = 1'b0;
    @(negedge clk);
    check("grace_free", 32'(free_slots), 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/park_billing.md
# park_billing

Ticketing and fee unit downstream of the car-park bar controller. On each admitted car it allocates a ticket (slot index) and timestamps it against a free-running seconds counter. On an exit request it looks up the ticket, computes the fee from the elapsed time and waits for payment. Only after payment does it release the slot and signal the controller to open the exit bar.

## Interface
- PMAX, 5: number of tickets/slots; ID_W = clog2(PMAX), minimum 1
- CLK_PER_SEC, 1000: clk cycles per second (1 ms clock)
- SEC_PER_HOUR, 3600: billing unit in seconds
- FEE_MAX, 5: fee cap; FEE_W = 4
- GRACE_SEC, 600: grace window; used only with PARK_GRACE_EN

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- entry_req  in  1  car admitted; held until entry_ack
- entry_ack  out  1  one-cycle pulse; ticket_id valid
- ticket_id  out  ID_W  allocated slot; valid only with entry_ack
- entry_full  out  1  level; free_slots == 0
- free_slots  out  ID_W+1  count of unallocated tickets
- exit_req  in  1  exit requested; held until fee_valid or exit_err
- exit_ticket  in  ID_W  ticket presented; stable while exit_req is high
- fee_valid  out  1  level, high in QUOTE; fee stable
- fee  out  FEE_W  amount due
- pay  in  1  payment accepted; sampled only in QUOTE
- paid  out  1  one-cycle pulse; open exit bar
- exit_err  out  1  one-cycle pulse; invalid or unallocated ticket
- now_sec  out  32  current seconds count

## Operation
- Timebase: prescaler counts 0..CLK_PER_SEC-1; now_sec increments on wrap and wraps modulo 2^32.
- Per-slot state: valid bit plus 32-bit entry timestamp.
- FSM states: IDLE, ALLOC, LOOKUP, QUOTE, RELEASE.
- IDLE:
  - entry_req && !entry_full → ALLOC. entry_req has priority over a simultaneous exit_req.
  - Otherwise exit_req → LOOKUP.
  - entry_req while full: ignored, stays IDLE, no ack.
- ALLOC:
  - Pick the lowest-index free slot; set its valid bit; timestamp = now_sec.
  - Drive entry_ack and ticket_id; → IDLE.
- LOOKUP:
  - If exit_ticket >= PMAX or its slot is not valid: exit_err, → IDLE.
  - Else register elapsed = now_sec - ts (modulo 2^32, wrap-safe); → QUOTE.
- QUOTE:
  - fee = min(FEE_MAX, floor(elapsed / SEC_PER_HOUR) + 1).
  - Computed by comparing elapsed against k*SEC_PER_HOUR for k = 1..FEE_MAX-1. No divider.
  - pay → RELEASE. Otherwise hold; there is no timeout.
- RELEASE: clear the valid bit, pulse paid, → IDLE.
- free_slots = PMAX minus the popcount of valid bits, updated the cycle after ALLOC or RELEASE.
- Requesters drop their request the cycle after the acknowledge. If a request is still high when the FSM returns to IDLE, it is serviced again.

## Timing
- Reset values:
  - State IDLE; all valid bits 0; prescaler 0; now_sec 0; free_slots = PMAX.
  - entry_ack, entry_full, fee_valid, paid, exit_err all 0; fee 0; ticket_id 0.
- Entry: entry_req sampled in IDLE at cycle N → entry_ack at N+1 → free_slots updated at N+2.
- Exit: exit_req sampled at N → LOOKUP at N+1 → fee_valid or exit_err at N+2.
- Payment: pay sampled in QUOTE at M → paid at M+1 → IDLE at M+2.
- Fee boundaries: elapsed SEC_PER_HOUR-1 → 1; elapsed SEC_PER_HOUR → 2; elapsed ≥ (FEE_MAX-1)*SEC_PER_HOUR → FEE_MAX.
- Reset mid-operation, in any state: next cycle state is IDLE, all tickets are lost, and all outputs take their reset values.

## Configuration
- PARK_GRACE_EN defined: when elapsed < GRACE_SEC in LOOKUP, fee = 0 and the FSM skips QUOTE. Flow is LOOKUP → RELEASE, so paid pulses at N+2 with no pay needed and fee_valid never rises.
- PARK_GRACE_EN undefined: minimum fee 1; GRACE_SEC has no effect.

## Structure
- park_pkg holds:
  - the FSM state encoding (3-bit);
  - FEE_W and TIME_W = 32;
  - the clog2 helper for ID_W.
- One sub-module, park_timebase, contains the prescaler and now_sec counter, with parameter CLK_PER_SEC.

## Test plan
Bench parameters: CLK_PER_SEC=1, SEC_PER_HOUR=10, PMAX=3.
- Entry: after reset, three entry_req handshakes → ticket_ids 0, 1, 2; free_slots 3→0; entry_full=1. A fourth entry_req gets no ack.
- Exit: enter, wait 9 s, exit that ticket → fee=1. Second run waits 10 s → fee=2. Third run waits 100 s → fee=5. pay → paid one cycle later; free_slots increments.
- Reuse: free ticket 1 with 0 and 2 still held; next entry → ticket_id=1.
- Invalid tickets: exit_ticket=3 → exit_err at N+2, no state change. An unallocated ticket → exit_err.
- Simultaneous requests: entry_req and exit_req in the same cycle → entry_ack first; the exit is serviced after entry_req drops.
- Reset and grace: rst asserted in QUOTE → fee_valid=0 next cycle, free_slots=3. With PARK_GRACE_EN and GRACE_SEC=5, an exit after 3 s → fee=0 and paid at N+2 with no pay.
